// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryption engine: one cipher round per clock with round keys expanded on the fly.
// The shared encryption_functions package holds the byte-level AES primitives.

package encryption_functions;

  typedef logic [127:0] block_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic block_t sub_bytes(input block_t s);
    block_t o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = SBOX[s[8*i +: 8]];
    return o;
  endfunction

  // Byte index is row + 4*column; row r rotates left by r columns.
  function automatic block_t shift_rows(input block_t s);
    block_t o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(r + 4*c) +: 8] = s[8*(r + 4*((c + r) % 4)) +: 8];
      end
    end
    return o;
  endfunction

  function automatic block_t mix_columns(input block_t s);
    block_t o;
    for (int c = 0; c < 4; c++) begin
      logic [7:0] a0, a1, a2, a3;
      a0 = s[32*c      +: 8];
      a1 = s[32*c + 8  +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      o[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // Next AES-128 round key: RotWord/SubWord of word 3, Rcon folded into byte 0.
  function automatic block_t key_generator(input block_t k, input logic [3:0] rnd);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {SBOX[k[103:96]], SBOX[k[127:120]], SBOX[k[119:112]], SBOX[k[111:104]] ^ rcon(rnd)};
    w0 = k[31:0]   ^ t;
    w1 = k[63:32]  ^ w0;
    w2 = k[95:64]  ^ w1;
    w3 = k[127:96] ^ w2;
    return {w3, w2, w1, w0};
  endfunction

  function automatic block_t main_cycle(input block_t s, input block_t k);
    return mix_columns(shift_rows(sub_bytes(s))) ^ k;
  endfunction

  function automatic block_t last_cycle(input block_t s, input block_t k);
    return shift_rows(sub_bytes(s)) ^ k;
  endfunction

endpackage

module aes_round_engine
  import encryption_functions::*;
#(
  parameter int BLOCK_BYTES = 16,
  parameter int NUM_ROUNDS  = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8*BLOCK_BYTES-1:0] in_block,
  input  logic [8*BLOCK_BYTES-1:0] in_key,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [8*BLOCK_BYTES-1:0] out_block,
  output logic                     busy
);

  if (BLOCK_BYTES != 16 || NUM_ROUNDS != 10) begin : g_bad_param
    $error("aes_round_engine supports only AES-128 (BLOCK_BYTES=16, NUM_ROUNDS=10)");
  end

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  block_t     data_q, data_d;
  block_t     key_q, key_d;
  block_t     round_key;
  logic [3:0] round_q, round_d;

  assign round_key = key_generator(key_q, round_q);

  // NOTE: every signal gets its hold value first so no path through the case leaves one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    key_d   = key_q;
    round_d = round_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_block ^ in_key;
          key_d   = in_key;
          round_d = 4'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (round_q == 4'd0 || round_q > LAST_ROUND) begin
          state_d = IDLE;
        end else begin
          key_d = round_key;
          if (round_q == LAST_ROUND) begin
            data_d  = last_cycle(data_q, round_key);
            state_d = DONE;
          end else begin
            data_d  = main_cycle(data_q, round_key);
            round_d = round_q + 4'd1;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      key_q   <= '0;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      key_q   <= key_d;
      round_q <= round_d;
    end
  end

  // Outputs decode only the state register, so in_ready never depends on in_valid.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_block = data_q;

endmodule
